// File: rtl/aes_ark_round_ctrl.sv
// Iterative AES encryption round register: AddRoundKey on the state returning
// from an external SubBytes/ShiftRows/MixColumns loop, plus round sequencing.
module aes_ark_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] mc_in,
  input  logic [127:0] sr_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] state_out,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } fsm_t;

  // Last round that still goes through MixColumns
  localparam logic [3:0] LP_LAST_MID = 4'(NR - 1);

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic [3:0]   r_round;
  logic [3:0]   w_round_next;
  logic [127:0] r_data;
  logic [127:0] w_data_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_round <= 4'd0;
      r_data  <= 128'd0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_round <= w_round_next;
      r_data  <= w_data_next;
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_round_next = r_round;
    w_data_next  = r_data;
    case (r_fsm)
      S_IDLE: begin
        if (in_valid) begin
          w_fsm_next   = S_ROUND;
          w_round_next = 4'd1;
          w_data_next  = pt_in ^ rk_data;
        end
      end
      S_ROUND: begin
        w_data_next  = mc_in ^ rk_data;
        w_round_next = r_round + 4'd1;
        if (r_round == LP_LAST_MID) begin
          w_fsm_next = S_FINAL;
        end
      end
      S_FINAL: begin
        // Final round skips MixColumns; the counter parks at NR
        w_data_next = sr_in ^ rk_data;
        w_fsm_next  = S_DONE;
      end
      S_DONE: begin
        // Ciphertext stays on state_out after hand-off until the next accept
        if (out_ready) begin
          w_fsm_next   = S_IDLE;
          w_round_next = 4'd0;
        end
      end
      default: begin
        w_fsm_next   = S_IDLE;
        w_round_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (r_fsm == S_IDLE);
    busy      = (r_fsm == S_ROUND) || (r_fsm == S_FINAL);
    out_valid = (r_fsm == S_DONE);
  end

  assign rk_idx    = r_round;
  assign state_out = r_data;

endmodule

// File: tb/tb_aes_ark_round_ctrl.sv
// Bench for aes_ark_round_ctrl: closes the SubBytes/ShiftRows/MixColumns loop
// with a reference model and serves round keys from a reference key schedule.
module tb_aes_ark_round_ctrl;

  typedef logic [127:0] rk_arr_t [0:15];
  typedef struct {
    logic         use_b;
    int           nr;
    logic [255:0] key;
    int           nk;
    logic [127:0] pt;
    logic [127:0] e0;
    logic [127:0] ct;
  } vec_t;

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E0_C1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- reference AES primitives ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      p = gmul(p, p);
      if (i != 0) p = gmul(p, a);
    end
    return p ^ rl(p, 1) ^ rl(p, 2) ^ rl(p, 3) ^ rl(p, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  function automatic rk_arr_t expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_arr_t     rks;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < 16; i++) rks[i] = 128'h0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < nk + 7; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  // ---------------- DUTs and loops ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, sel_b;
  logic [127:0] pt_in;
  rk_arr_t      rk_a, rk_b;
  int           n_checks = 0;
  int           n_fail = 0;

  logic         in_valid_a, in_ready_a, busy_a, out_valid_a;
  logic [3:0]   rk_idx_a;
  logic [127:0] state_a, mc_a, sr_a, rk_data_a;
  logic         in_valid_b, in_ready_b, busy_b, out_valid_b;
  logic [3:0]   rk_idx_b;
  logic [127:0] state_b, mc_b, sr_b, rk_data_b;

  assign in_valid_a = in_valid & ~sel_b;
  assign in_valid_b = in_valid & sel_b;
  assign sr_a       = shift_rows(sub_bytes(state_a));
  assign mc_a       = mix_columns(sr_a);
  assign rk_data_a  = rk_a[rk_idx_a];
  assign sr_b       = shift_rows(sub_bytes(state_b));
  assign mc_b       = mix_columns(sr_b);
  assign rk_data_b  = rk_b[rk_idx_b];

  aes_ark_round_ctrl #(.NR(10)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .pt_in(pt_in), .mc_in(mc_a), .sr_in(sr_a), .rk_idx(rk_idx_a),
    .rk_data(rk_data_a), .state_out(state_a), .busy(busy_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  aes_ark_round_ctrl #(.NR(14)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .pt_in(pt_in), .mc_in(mc_b), .sr_in(sr_b), .rk_idx(rk_idx_b),
    .rk_data(rk_data_b), .state_out(state_b), .busy(busy_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  logic         obs_in_ready, obs_busy, obs_out_valid;
  logic [3:0]   obs_rk_idx;
  logic [127:0] obs_state;
  assign obs_in_ready  = sel_b ? in_ready_b  : in_ready_a;
  assign obs_busy      = sel_b ? busy_b      : busy_a;
  assign obs_out_valid = sel_b ? out_valid_b : out_valid_a;
  assign obs_rk_idx    = sel_b ? rk_idx_b    : rk_idx_a;
  assign obs_state     = sel_b ? state_b     : state_a;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, " in_ready"},  128'(obs_in_ready),  128'd1);
    chk({nm, " busy"},      128'(obs_busy),      128'd0);
    chk({nm, " out_valid"}, 128'(obs_out_valid), 128'd0);
    chk({nm, " rk_idx"},    128'(obs_rk_idx),    128'd0);
    chk({nm, " state_out"}, obs_state,           128'd0);
  endtask

  task automatic wait_done(input string nm, input int exp_k);
    int k;
    k = 0;
    while (!obs_out_valid && k < 40) begin
      step();
      k++;
    end
    chk({nm, " cycles to out_valid"}, 128'(k), 128'(exp_k));
  endtask

  // Accepts one block and follows it to DONE, checking rk_idx every cycle
  task automatic accept_and_wait(input int tag, input int nr, input logic [127:0] pt,
                                 input logic [127:0] e0);
    int k;
    chk($sformatf("v%0d idle in_ready", tag), 128'(obs_in_ready), 128'd1);
    chk($sformatf("v%0d idle rk_idx", tag),   128'(obs_rk_idx),   128'd0);
    pt_in    = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk($sformatf("v%0d state after E0", tag), obs_state, e0);
    k = 0;
    while (!obs_out_valid && k < nr + 4) begin
      chk($sformatf("v%0d rk_idx E0+%0d", tag, k), 128'(obs_rk_idx), 128'(k + 1));
      chk($sformatf("v%0d busy E0+%0d", tag, k),   128'(obs_busy),   128'd1);
      step();
      k++;
    end
    chk($sformatf("v%0d latency", tag), 128'(k), 128'(nr));
  endtask

  task automatic run_block(input int tag, input int nr, input logic [127:0] pt,
                           input logic [127:0] e0, input logic [127:0] ct);
    accept_and_wait(tag, nr, pt, e0);
    chk($sformatf("v%0d ciphertext", tag),  obs_state,            ct);
    chk($sformatf("v%0d done busy", tag),   128'(obs_busy),       128'd0);
    chk($sformatf("v%0d done in_ready", tag), 128'(obs_in_ready), 128'd0);
    chk($sformatf("v%0d done rk_idx", tag), 128'(obs_rk_idx),     128'(nr));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d drained out_valid", tag), 128'(obs_out_valid), 128'd0);
    chk($sformatf("v%0d drained in_ready", tag),  128'(obs_in_ready),  128'd1);
    chk($sformatf("v%0d drained rk_idx", tag),    128'(obs_rk_idx),    128'd0);
    chk($sformatf("v%0d ct kept", tag),           obs_state,           ct);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs [0:2];
    int   pulses;

    vecs[0] = '{1'b0, 10, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h193de3bea0f4e22b9ac68d2ae9f84808,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{1'b0, 10, KEY_C1, 4, PT_C1, E0_C1, CT_C1};
    vecs[2] = '{1'b1, 14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8,
                PT_C1, E0_C1, 128'h8ea2b7ca516745bfeafc49904b496089};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel_b     = 1'b0;
    pt_in     = 128'h0;
    rk_a      = expand_key(vecs[0].key, vecs[0].nk);
    rk_b      = expand_key(vecs[2].key, vecs[2].nk);
    repeat (3) step();
    rst = 1'b0;
    check_reset("reset A");
    sel_b = 1'b1;
    #1;
    check_reset("reset B");

    for (int v = 0; v < 3; v++) begin
      sel_b = vecs[v].use_b;
      #1;
      if (vecs[v].use_b) rk_b = expand_key(vecs[v].key, vecs[v].nk);
      else               rk_a = expand_key(vecs[v].key, vecs[v].nk);
      run_block(v, vecs[v].nr, vecs[v].pt, vecs[v].e0, vecs[v].ct);
    end
    sel_b = 1'b0;
    #1;

    // Backpressure: five cycles held in DONE
    accept_and_wait(10, 10, PT_C1, E0_C1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d out_valid", i), 128'(obs_out_valid), 128'd1);
      chk($sformatf("bp%0d state", i),     obs_state,           CT_C1);
      chk($sformatf("bp%0d in_ready", i),  128'(obs_in_ready),  128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp release out_valid", 128'(obs_out_valid), 128'd0);
    chk("bp release in_ready",  128'(obs_in_ready),  128'd1);

    // Foreign plaintext offered during rounds 3..6 must be ignored
    pt_in    = PT_C1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rej rk_idx at round 3", 128'(obs_rk_idx), 128'd3);
    pt_in    = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rej in_ready round %0d", i + 3), 128'(obs_in_ready), 128'd0);
      step();
    end
    in_valid = 1'b0;
    wait_done("rej", 4);
    chk("rej ciphertext", obs_state, CT_C1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Back-to-back: in_valid and out_ready both high in DONE
    accept_and_wait(11, 10, PT_C1, E0_C1);
    pt_in     = PT_C1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("b2b exit out_valid", 128'(obs_out_valid), 128'd0);
    chk("b2b exit in_ready",  128'(obs_in_ready),  128'd1);
    chk("b2b exit busy",      128'(obs_busy),      128'd0);
    chk("b2b exit rk_idx",    128'(obs_rk_idx),    128'd0);
    step();
    in_valid = 1'b0;
    chk("b2b accept busy",   128'(obs_busy),   128'd1);
    chk("b2b accept rk_idx", 128'(obs_rk_idx), 128'd1);
    chk("b2b accept state",  obs_state,        E0_C1);
    wait_done("b2b", 10);
    chk("b2b ciphertext", obs_state, CT_C1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Abort at round 5
    pt_in    = PT_C1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("abort rk_idx at round 5", 128'(obs_rk_idx), 128'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("abort");
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (obs_out_valid) pulses++;
      step();
    end
    chk("abort out_valid pulses", 128'(pulses), 128'd0);
    run_block(20, 10, PT_C1, E0_C1, CT_C1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
